// File: rtl/bf_pkg.sv
// Shared Output Memory geometry and streamer state encoding used by the
// bellmanford result path.
package bf_pkg;

  localparam int              OM_ADDR_W = 13;
  localparam int              OM_DATA_W = 16;
  localparam int              OM_DEPTH  = 8192;
  localparam logic [15:0]     DIST_INF  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } om_state_e;

endpackage

// File: rtl/om_result_streamer_stream_out_reg.sv
// Single-entry valid/ready output register carrying a distance word and its
// INF / negative-cycle / last flags.
module stream_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_inf,
  input  logic              load_neg,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_inf,
  output logic              out_neg,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              inf_q,   inf_d;
  logic              neg_q,   neg_d;
  logic              last_q,  last_d;

  // Next entry contents: load overwrites, an accept without load empties it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    inf_d   = inf_q;
    neg_d   = neg_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      inf_d   = load_inf;
      neg_d   = load_neg;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry state flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      inf_q   <= 1'b0;
      neg_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      inf_q   <= inf_d;
      neg_q   <= neg_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_inf   = inf_q;
  assign out_neg   = neg_q;
  assign out_last  = last_q;

endmodule

// File: rtl/om_result_streamer.sv
// Scans bellmanford's Output Memory after Finish and streams each distance
// word on a valid/ready port, or emits one status word on NegCycle.
module om_result_streamer
  import bf_pkg::*;
#(
  parameter int                ADDR_W = OM_ADDR_W,
  parameter int                DATA_W = OM_DATA_W,
  parameter int                DEPTH  = OM_DEPTH,
  parameter logic [DATA_W-1:0] INF    = DIST_INF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_inf,
  output logic              out_neg,
  output logic              out_last,
  output logic              Done
);

  // One spare address bit lets the counter reach DEPTH when DEPTH == 2^ADDR_W.
  localparam int             CW      = ADDR_W + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);

  om_state_e         state_q, state_d;
  logic [CW-1:0]     addr_q,  addr_d;
  logic              done_q,  done_d;

  logic              words_left_s;
  logic              load_s;
  logic [DATA_W-1:0] ld_data_s;
  logic              ld_inf_s;
  logic              ld_neg_s;
  logic              ld_last_s;

  assign words_left_s = (addr_q < DEPTH_C);

  // Next-state, address and output-register load decisions.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    load_s    = 1'b0;
    ld_data_s = '0;
    ld_inf_s  = 1'b0;
    ld_neg_s  = 1'b0;
    ld_last_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (NegCycle) begin
          state_d = ST_NEG;
        end else if (Finish) begin
          state_d = ST_SCAN;
          addr_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if ((!out_valid || out_ready) && words_left_s) begin
          load_s    = 1'b1;
          ld_data_s = OMDR;
          ld_inf_s  = (OMDR == INF);
          ld_last_s = (addr_q == LAST_C);
          addr_d    = addr_q + CW'(1);
        end else if (out_valid && out_ready && out_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_NEG: begin
        if (!out_valid) begin
          load_s    = 1'b1;
          ld_data_s = INF;
          ld_inf_s  = 1'b1;
          ld_neg_s  = 1'b1;
          ld_last_s = 1'b1;
        end else if (out_ready) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_NEG;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  // FSM, address counter and sticky Done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // Once the final word is fetched the counter sits at DEPTH; keep the read
  // address pinned to the last valid word instead of running off the end.
  assign OMAR = words_left_s ? addr_q[ADDR_W-1:0] : LAST_C[ADDR_W-1:0];
  assign Done = done_q;

  stream_out_reg #(
    .DATA_W (DATA_W)
  ) u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (load_s),
    .load_data (ld_data_s),
    .load_inf  (ld_inf_s),
    .load_neg  (ld_neg_s),
    .load_last (ld_last_s),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_inf   (out_inf),
    .out_neg   (out_neg),
    .out_last  (out_last)
  );

endmodule
